// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding, per-cycle control vector and
// the canned control patterns each hazard produces.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MDU_BUSY = 2'd2,
        MEM_WAIT = 2'd3
    } pipe_state_e;

    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF       = 16;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic flush_mem_wb;
        logic pc_redirect;
        logic bus_err;
    } ctrl_t;

    localparam ctrl_t CTRL_INIT = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_ex_mem: 1'b1,
                                    flush_mem_wb: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_BERR = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_ex_mem: 1'b1,
                                    flush_mem_wb: 1'b1, bus_err: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_MEM  = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                    stall_ex_mem: 1'b1, flush_mem_wb: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_MDU  = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                    flush_ex_mem: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_JUMP = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, pc_redirect: 1'b1,
                                    default: 1'b0};
    localparam ctrl_t CTRL_LU   = '{stall_pc: 1'b1, stall_if_id: 1'b1, flush_id_ex: 1'b1,
                                    default: 1'b0};

    // A flushed stage must load the NOP, so flush always overrides its stall.
    function automatic ctrl_t resolve(input ctrl_t c);
        ctrl_t r;
        r              = c;
        r.stall_pc     = c.stall_pc     & ~c.pc_redirect;
        r.stall_if_id  = c.stall_if_id  & ~c.flush_if_id;
        r.stall_id_ex  = c.stall_id_ex  & ~c.flush_id_ex;
        r.stall_ex_mem = c.stall_ex_mem & ~c.flush_ex_mem;
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-request / stall-flush bundle between the pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             jump_req;
    logic [31:0]      jump_addr;
    logic             load_use;
    logic             mdu_start;
    logic             mdu_done;
    logic             mem_req;
    logic             mem_ready;
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             flush_mem_wb;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output jump_req, jump_addr, load_use, mdu_start, mdu_done, mem_req, mem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               pc_redirect, pc_target, bus_err, stall_cnt
    );

    modport slave (
        input  jump_req, jump_addr, load_use, mdu_start, mdu_done, mem_req, mem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               pc_redirect, pc_target, bus_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates memory, mul/div, jump and load-use hazards
// into per-stage stall/flush controls with a bus-error timeout on memory waits.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic         clock,
    input logic         reset_n,
    pipe_ctrl_if.slave  bus
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_e       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    ctrl_t             w_raw;
    ctrl_t             w_ctrl;
    logic              w_any_stall;
    logic [CNT_W-1:0]  w_stall_cnt;

    always_comb begin
        w_raw = '0;
        case (r_state)
            INIT: w_raw = CTRL_INIT;
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) w_raw = CTRL_MEM;
                else if (bus.mdu_start)            w_raw = CTRL_MDU;
                else if (bus.jump_req)             w_raw = CTRL_JUMP;
                else if (bus.load_use)             w_raw = CTRL_LU;
            end
            MDU_BUSY: if (!bus.mdu_done) w_raw = CTRL_MDU;
            // r_wait_cnt counts cycles already waited, so this cycle is wait number r_wait_cnt+1.
            MEM_WAIT: if (!bus.mem_ready) w_raw = (r_wait_cnt >= LAST_WAIT) ? CTRL_BERR : CTRL_MEM;
            default: w_raw = '0;
        endcase
        w_ctrl = resolve(w_raw);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                INIT: r_state <= RUN;
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end else if (bus.mdu_start) begin
                        r_state <= MDU_BUSY;
                    end
                end
                MDU_BUSY: if (bus.mdu_done) r_state <= RUN;
                MEM_WAIT: begin
                    if (bus.mem_ready || (r_wait_cnt >= LAST_WAIT)) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign w_any_stall = w_ctrl.stall_pc | w_ctrl.stall_if_id |
                         w_ctrl.stall_id_ex | w_ctrl.stall_ex_mem;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .i_inc (w_any_stall),
        .o_cnt (w_stall_cnt)
    );

    assign bus.stall_pc     = w_ctrl.stall_pc;
    assign bus.stall_if_id  = w_ctrl.stall_if_id;
    assign bus.stall_id_ex  = w_ctrl.stall_id_ex;
    assign bus.stall_ex_mem = w_ctrl.stall_ex_mem;
    assign bus.flush_if_id  = w_ctrl.flush_if_id;
    assign bus.flush_id_ex  = w_ctrl.flush_id_ex;
    assign bus.flush_ex_mem = w_ctrl.flush_ex_mem;
    assign bus.flush_mem_wb = w_ctrl.flush_mem_wb;
    assign bus.pc_redirect  = w_ctrl.pc_redirect;
    assign bus.pc_target    = w_ctrl.pc_redirect ? bus.jump_addr : 32'h0;
    assign bus.bus_err      = w_ctrl.bus_err;
    assign bus.stall_cnt    = w_stall_cnt;
endmodule
